card_board_ctrl: RTL

Holds the 16-card board image and the player's cursor, and acts as the selecting side of the gameplay_sm card-select interface. It presents CardSelectLoc/CardSelectData and raises Select. It then holds both stable until gameplay_sm returns Ack. In the other direction, it accepts gameplay_sm board writes (WriteEnable/dataLoc/dataOut). It also provides an asynchronous read port for the VGA renderer.

---
 rtl/card_pkg.sv | 31 +++
 rtl/card_board_ram.sv | 50 +++++
 rtl/card_board_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// card_pkg: constants and types shared by the card board controller and the
// gameplay state machine.
//   - Board geometry: NUM_CARDS entries arranged as a GRID_W x GRID_W grid.
//   - Card word layout: bit MATCHED_BIT = matched, bit FACEUP_BIT = face up,
//     bits VALUE_MSB:0 = card value.
//   - Encoding of the card-select handshake states.
package card_pkg;

  localparam int NUM_CARDS   = 16;
  localparam int GRID_W      = 4;
  localparam int DATA_W      = 6;
  localparam int LOC_W       = 4;
  // Cursor row and column each use half of the location index.
  localparam int AXIS_W      = LOC_W / 2;

  localparam int MATCHED_BIT = 5;
  localparam int FACEUP_BIT  = 4;
  localparam int VALUE_MSB   = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REQ          = 2'd1,
    WAIT_ACK_LOW = 2'd2
  } sel_state_e;

  // A card may be selected only while it is face down and not yet matched.
  function automatic logic card_selectable(input logic [DATA_W-1:0] word);
    return !word[MATCHED_BIT] && !word[FACEUP_BIT];
  endfunction

endpackage

// File: rtl/card_board_ram.sv
// card_board_ram: NUM_CARDS x DATA_W board register file.
//   clk, rst      : clock and asynchronous active-high reset (clears all entries)
//   clear         : synchronous clear of every entry, wins over a write
//   we/waddr/wdata: single write port, visible from the next cycle
//   raddr_a/rdata_a, raddr_b/rdata_b : two combinational read ports
module card_board_ram
  import card_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic [LOC_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LOC_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [LOC_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NUM_CARDS];
  logic [DATA_W-1:0] mem_d [NUM_CARDS];

  always_comb begin
    for (int i = 0; i < NUM_CARDS; i++) begin
      mem_d[i] = mem_q[i];
      if (clear) begin
        mem_d[i] = '0;
      end else if (we && (waddr == LOC_W'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/card_board_ctrl.sv
// card_board_ctrl: board image, player cursor and the selecting side of the
// card-select handshake with gameplay_sm.
//   Clk, Reset          : clock, asynchronous active-high reset
//   BtnU/D/L/R          : single-cycle cursor move pulses (wrap per axis)
//   BtnC                : select the card under the cursor
//   ClearBoard          : clear all board entries (beats WriteEnable)
//   WriteEnable/dataLoc/dataOut : board write port from gameplay_sm
//   Ack                 : gameplay_sm accepts the current selection
//   Select, CardSelectLoc, CardSelectData : registered selection request
//   Cursor              : live cursor location
//   Reject              : one-cycle pulse when BtnC hits a face-up/matched card
//   DispLoc/DispData    : combinational read port for the renderer
//   Busy                : handshake in progress (REQ or WAIT_ACK_LOW)
module card_board_ctrl
  import card_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BtnU,
  input  logic              BtnD,
  input  logic              BtnL,
  input  logic              BtnR,
  input  logic              BtnC,
  input  logic              ClearBoard,
  input  logic              WriteEnable,
  input  logic [LOC_W-1:0]  dataLoc,
  input  logic [DATA_W-1:0] dataOut,
  input  logic              Ack,
  output logic              Select,
  output logic [LOC_W-1:0]  CardSelectLoc,
  output logic [DATA_W-1:0] CardSelectData,
  output logic [LOC_W-1:0]  Cursor,
  output logic              Reject,
  input  logic [LOC_W-1:0]  DispLoc,
  output logic [DATA_W-1:0] DispData,
  output logic              Busy
);

  sel_state_e        state_q, state_d;
  logic [LOC_W-1:0]  cursor_q, cursor_d;
  logic              select_q, select_d;
  logic [LOC_W-1:0]  sel_loc_q, sel_loc_d;
  logic [DATA_W-1:0] sel_data_q, sel_data_d;
  logic              reject_q, reject_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] cursor_word;
  logic [AXIS_W-1:0] row, col, row_d, col_d;

  card_board_ram u_ram (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (ClearBoard),
    .we      (WriteEnable),
    .waddr   (dataLoc),
    .wdata   (dataOut),
    .raddr_a (DispLoc),
    .rdata_a (DispData),
    .raddr_b (cursor_q),
    .rdata_b (cursor_word)
  );

  assign row = cursor_q[LOC_W-1:AXIS_W];
  assign col = cursor_q[AXIS_W-1:0];

  always_comb begin
    state_d    = state_q;
    sel_loc_d  = sel_loc_q;
    sel_data_d = sel_data_q;
    reject_d   = 1'b0;
    row_d      = row;
    col_d      = col;

    unique case (state_q)
      IDLE: begin
        // BtnC wins over a coincident move: select uses the pre-move cursor.
        if (BtnC) begin
          if (card_selectable(cursor_word)) begin
            sel_loc_d  = cursor_q;
            sel_data_d = cursor_word;
            state_d    = REQ;
          end else begin
            reject_d = 1'b1;
          end
        end else if (BtnU) begin
          row_d = row - AXIS_W'(1);
        end else if (BtnD) begin
          row_d = row + AXIS_W'(1);
        end else if (BtnL) begin
          col_d = col - AXIS_W'(1);
        end else if (BtnR) begin
          col_d = col + AXIS_W'(1);
        end
      end
      REQ: begin
        if (Ack) state_d = WAIT_ACK_LOW;
      end
      WAIT_ACK_LOW: begin
        // Wait for Ack to drop so a long Ack cannot satisfy a second request.
        if (!Ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cursor_d = {row_d, col_d};
    select_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cursor_q   <= '0;
      select_q   <= 1'b0;
      sel_loc_q  <= '0;
      sel_data_q <= '0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      select_q   <= select_d;
      sel_loc_q  <= sel_loc_d;
      sel_data_q <= sel_data_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign Select         = select_q;
  assign CardSelectLoc  = sel_loc_q;
  assign CardSelectData = sel_data_q;
  assign Cursor         = cursor_q;
  assign Reject         = reject_q;
  assign Busy           = busy_q;

endmodule
